// File: rtl/array_sequencer_pkg.sv
// Shared types and sizing for the 8x8 array sequencer.
package array_sequencer_pkg;

  localparam int ARRAY_SIZE = 8;
  localparam int ROW_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    READ,
    DONE
  } seq_state_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO holding whole result rows between the array and the result port.
module result_fifo2 #(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic signed [WIDTH-1:0] din  [LEN],
  output logic signed [WIDTH-1:0] dout [LEN],
  output logic                    empty,
  output logic [1:0]              count
);

  logic signed [WIDTH-1:0] mem [2][LEN];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  // A pop only counts when there is data; a push into a full FIFO is accepted only alongside a pop.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign empty   = (count == 2'd0);

  // Storage, pointers and occupancy; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < LEN; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      if (do_push) begin
        for (int j = 0; j < LEN; j++) begin
          mem[wr_ptr][j] <= din[j];
        end
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head of the FIFO is always visible.
  always_comb begin
    for (int j = 0; j < LEN; j++) begin
      dout[j] = mem[rd_ptr][j];
    end
  end

endmodule

// File: rtl/array_sequencer.sv
// Sequences one 8x8 job: load A rows / B columns, run the array, read result rows out.
module array_sequencer
  import array_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int WRITE_START    = 8,
  parameter int COMPUTE_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic signed [DATA_WIDTH-1:0] ld_a [ARRAY_SIZE],
  input  logic signed [DATA_WIDTH-1:0] ld_b [ARRAY_SIZE],
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [ACC_WIDTH-1:0]  res_c [ARRAY_SIZE],
  output logic                         arr_enable,
  output logic                         arr_input_write,
  output logic                         arr_output_write,
  output logic                         arr_output_read,
  output logic [ROW_W-1:0]             arr_row_ptr,
  output logic signed [DATA_WIDTH-1:0] arr_a_in [ARRAY_SIZE],
  output logic signed [DATA_WIDTH-1:0] arr_b_in [ARRAY_SIZE],
  input  logic                         arr_read_valid,
  input  logic signed [ACC_WIDTH-1:0]  arr_c_out [ARRAY_SIZE]
);

  localparam int                CNT_W    = $clog2(COMPUTE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_FIRST = CNT_W'(WRITE_START);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WRITE_START + 7);

  seq_state_t                   state;
  seq_state_t                   state_next;
  logic [ROW_W-1:0]             load_idx;
  logic [CNT_W-1:0]             cycle_cnt;
  logic [3:0]                   reads_issued;
  logic [3:0]                   pops_done;
  logic [1:0]                   outstanding;
  logic [1:0]                   fifo_count;
  logic                         fifo_empty;
  logic signed [ACC_WIDTH-1:0]  fifo_head [ARRAY_SIZE];
  logic                         beat_accept;
  logic                         issue_read;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         in_write_window;

  // Read credit depends only on registered occupancy, so res_ready never reaches arr_output_read.
  assign beat_accept     = (state == LOAD) && ld_valid;
  assign issue_read      = (state == READ) &&
                           (({1'b0, fifo_count} + {1'b0, outstanding}) < 3'd2) &&
                           (reads_issued < 4'd8);
  assign fifo_push       = arr_read_valid && (outstanding != 2'd0);
  assign fifo_pop        = !fifo_empty && res_ready;
  assign in_write_window = (state == COMPUTE) && (cycle_cnt >= WR_FIRST) && (cycle_cnt <= WR_LAST);

  result_fifo2 #(
    .WIDTH (ACC_WIDTH),
    .LEN   (ARRAY_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (arr_c_out),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (beat_accept && (load_idx == 3'd7)) state_next = COMPUTE;
      COMPUTE: if (cycle_cnt == LAST_CNT) state_next = READ;
      READ:    if (fifo_pop && (pops_done == 4'd7)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat index, compute cycle count, read/pop counts and in-flight reads; all cleared while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_idx     <= '0;
      cycle_cnt    <= '0;
      reads_issued <= '0;
      pops_done    <= '0;
      outstanding  <= '0;
    end else begin
      case (state)
        IDLE: begin
          load_idx     <= '0;
          cycle_cnt    <= '0;
          reads_issued <= '0;
          pops_done    <= '0;
          outstanding  <= '0;
        end
        LOAD: begin
          if (beat_accept) load_idx <= load_idx + 3'd1;
        end
        COMPUTE: begin
          cycle_cnt <= (cycle_cnt == LAST_CNT) ? '0 : cycle_cnt + 1'b1;
        end
        READ: begin
          reads_issued <= reads_issued + {3'd0, issue_read};
          pops_done    <= pops_done + {3'd0, fifo_pop};
          outstanding  <= outstanding + {1'b0, issue_read} - {1'b0, fifo_push};
        end
        default: begin
        end
      endcase
    end
  end

  // Control outputs and datapath pass-through; data buses are held at zero during reset.
  always_comb begin
    busy             = (state != IDLE);
    done             = (state == DONE);
    ld_ready         = (state == LOAD);
    arr_enable       = (state == LOAD) || (state == COMPUTE) || (state == READ);
    arr_input_write  = beat_accept;
    arr_output_write = in_write_window;
    arr_output_read  = issue_read;
    res_valid        = !fifo_empty;
    arr_row_ptr      = '0;
    case (state)
      LOAD:    arr_row_ptr = load_idx;
      COMPUTE: if (in_write_window) arr_row_ptr = ROW_W'(cycle_cnt - WR_FIRST);
      READ:    arr_row_ptr = reads_issued[ROW_W-1:0];
      default: arr_row_ptr = '0;
    endcase
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      arr_a_in[j] = rst ? '0 : ld_a[j];
      arr_b_in[j] = rst ? '0 : ld_b[j];
      res_c[j]    = rst ? '0 : fifo_head[j];
    end
  end

endmodule

// File: doc/array_sequencer.md
ARRAY_SEQUENCER -- requirements
Module: array_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, operand width; ACC_WIDTH, default 32, result width; WRITE_START, default 8, compute cycle of first arr_output_write; COMPUTE_CYCLES, default 16, total compute cycles, at least WRITE_START+8.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  begins one 8x8 job when in IDLE; busy  out  1  high outside IDLE; done  out  1  one-cycle pulse at job end.
REQ-005 ld_valid  in  1; ld_ready  out  1; ld_a[8]  in  DATA_WIDTH signed, A row; ld_b[8]  in  DATA_WIDTH signed, B column.
REQ-006 res_valid  out  1; res_ready  in  1; res_c[8]  out  ACC_WIDTH signed, one result row per beat.
REQ-007 arr_enable, arr_input_write, arr_output_write, arr_output_read  out  1; arr_row_ptr  out  3; arr_a_in[8], arr_b_in[8]  out  DATA_WIDTH signed.
REQ-008 arr_read_valid  in  1; arr_c_out[8]  in  ACC_WIDTH signed; these drive the 8x8 array's matching ports.

Function
REQ-009 FSM states SHALL be IDLE, LOAD, COMPUTE, READ, DONE.
REQ-010 IDLE->LOAD on start; start while busy SHALL be ignored.
REQ-011 LOAD: ld_ready=1; each ld_valid&&ld_ready beat SHALL assert arr_input_write that cycle, with arr_row_ptr = beat index 0..7 and arr_a_in/arr_b_in = ld_a/ld_b combinationally.
REQ-012 No arr_input_write SHALL occur without an accepted beat; ld_valid gaps SHALL stall LOAD.
REQ-013 After beat 7, LOAD->COMPUTE; ld_ready SHALL be 0 outside LOAD.
REQ-014 COMPUTE SHALL last exactly COMPUTE_CYCLES cycles, counted 0..COMPUTE_CYCLES-1 by a cycle counter.
REQ-015 arr_output_write SHALL be 1 for counts WRITE_START..WRITE_START+7 inclusive, else 0.
REQ-016 After count COMPUTE_CYCLES-1, COMPUTE->READ.
REQ-017 READ SHALL use a 2-entry result FIFO plus an outstanding-read counter.
REQ-018 arr_output_read SHALL pulse only when FIFO occupancy + outstanding < 2 and fewer than 8 reads have been issued.
REQ-019 Each arr_read_valid cycle SHALL push arr_c_out into the FIFO and decrement outstanding; arr_read_valid with outstanding=0 SHALL be ignored.
REQ-020 res_valid = FIFO non-empty; res_c = FIFO head; pop on res_valid&&res_ready.
REQ-021 Simultaneous push and pop SHALL keep occupancy unchanged; the FIFO SHALL never overflow.
REQ-022 After the 8th pop, READ->DONE; DONE asserts done for one cycle, then goes to IDLE.
REQ-023 arr_enable SHALL be 1 in LOAD, COMPUTE and READ, and 0 in IDLE and DONE.
REQ-024 res_c SHALL pass ACC_WIDTH values unmodified; no truncation or saturation.

Reset
REQ-025 rst SHALL force IDLE and clear all counters, FIFO and outstanding count, even mid-job.
REQ-026 Reset values SHALL be busy=0, done=0, ld_ready=0, res_valid=0, all arr_* controls=0, arr_row_ptr=0.
REQ-027 res_c, arr_a_in and arr_b_in SHALL read 0 while reset is asserted.

Structure
REQ-028 A shared package SHALL hold the state enum (seq_state_t), ARRAY_SIZE=8 and the row-index width (3).
REQ-029 The result FIFO SHALL be one sub-module, result_fifo2, parameterised by width and vector length.
REQ-030 All other logic SHALL be in array_sequencer, with no combinational path from res_ready to arr_output_read.

Verification
REQ-031 Reset mid-LOAD after 3 beats -> IDLE next edge, busy=0, the next job starts with arr_row_ptr=0.
REQ-032 Job with ld_valid held 1 -> arr_input_write for 8 consecutive cycles, arr_row_ptr 0..7; arr_output_write at compute counts 8..15.
REQ-033 ld_valid toggling 1,0,1,0 -> arr_input_write only on accepted beats, row_ptr contiguous.
REQ-034 A=identity, B[i][j]=i*8+j -> res_c rows equal B in order 0..7, then done=1 for exactly one cycle.
REQ-035 res_ready=0 for 20 cycles in READ -> at most 2 arr_output_read pulses, no result lost; then 8 rows total.
REQ-036 A all -128, B all -128 -> every res_c element = 131072 (8 x 16384), no wrap.
